wb_stage_inorder: RTL

- Parametrised write-back stage for the ARM pipeline; successor to the single-mux WB stage.
- Sits between MEM stage and register file. Holds up to DEPTH in-flight instructions and tolerates variable-latency data-memory loads.
- Extracts byte/halfword load data, with sign or zero extension.
- Retires strictly in program order: one register-file write per cycle, plus a busy mask for the hazard unit.

---
 rtl/wb_stage_inorder_if.sv | 36 +++
 rtl/wb_stage_inorder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage_inorder_if.sv
// Bus bundle for the in-order write-back stage: MEM-stage issue handshake,
// data-memory response channel and the register-file write-back port.
interface wb_stage_inorder_if #(
  parameter int BIT_NUMBER = 32,
  parameter int REG_ADDR_W = 4
);
  logic                         in_valid;
  logic                         in_ready;
  logic [BIT_NUMBER-1:0]        ALU_result;
  logic                         Mem_R_en;
  logic                         WB_en_in;
  logic [REG_ADDR_W-1:0]        Dest_in;
  logic [1:0]                   ld_size;
  logic                         ld_signed;
  logic                         mem_rsp_valid;
  logic [BIT_NUMBER-1:0]        mem_rsp_data;
  logic [BIT_NUMBER-1:0]        out;
  logic                         WB_en;
  logic [REG_ADDR_W-1:0]        Dest;
  logic [(2**REG_ADDR_W)-1:0]   busy_mask;
  logic                         rsp_err;

  // MEM stage / memory / register-file side
  modport master (
    output in_valid, ALU_result, Mem_R_en, WB_en_in, Dest_in, ld_size, ld_signed,
    output mem_rsp_valid, mem_rsp_data,
    input  in_ready, out, WB_en, Dest, busy_mask, rsp_err
  );

  // write-back stage side
  modport slave (
    input  in_valid, ALU_result, Mem_R_en, WB_en_in, Dest_in, ld_size, ld_signed,
    input  mem_rsp_valid, mem_rsp_data,
    output in_ready, out, WB_en, Dest, busy_mask, rsp_err
  );
endinterface

// File: rtl/wb_stage_inorder.sv
// In-order write-back stage. A small circular buffer holds in-flight
// instructions; loads wait for their memory word (returned in issue order),
// sub-word data is extracted at retirement, and one entry retires per cycle
// strictly from the head. busy_mask tells the hazard unit which registers
// still have a pending write.
module wb_stage_inorder #(
  parameter int BIT_NUMBER = 32,
  parameter int REG_ADDR_W = 4,
  parameter int DEPTH      = 2
) (
  input logic               clk,
  input logic               rst,
  wb_stage_inorder_if.slave bus
);
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NREG = 2 ** REG_ADDR_W;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [PW:0]   cnt_t;

  localparam cnt_t DEPTH_C = cnt_t'(DEPTH);

  // Selects the final write-back value of a retiring load from its memory word.
  function automatic logic [BIT_NUMBER-1:0] extract_load(
    input logic [BIT_NUMBER-1:0] w,
    input logic [1:0]            size,
    input logic                  sgn,
    input logic [1:0]            alo
  );
    logic [15:0]           half_v;
    logic [7:0]            byte_v;
    logic [BIT_NUMBER-1:0] r_v;
    half_v = alo[1] ? w[31:16] : w[15:0];
    case (alo)
      2'b00:   byte_v = w[7:0];
      2'b01:   byte_v = w[15:8];
      2'b10:   byte_v = w[23:16];
      2'b11:   byte_v = w[31:24];
      default: byte_v = w[7:0];
    endcase
    case (size)
      2'b01:   r_v = sgn ? {{(BIT_NUMBER-16){half_v[15]}}, half_v}
                         : {{(BIT_NUMBER-16){1'b0}}, half_v};
      2'b10:   r_v = sgn ? {{(BIT_NUMBER-8){byte_v[7]}}, byte_v}
                         : {{(BIT_NUMBER-8){1'b0}}, byte_v};
      default: r_v = w;
    endcase
    return r_v;
  endfunction

  // True when slot idx lies inside the occupied window starting at rd.
  function automatic logic entry_live(input ptr_t idx, input ptr_t rd, input cnt_t cnt);
    ptr_t off_v;
    off_v = idx - rd;
    return ({1'b0, off_v} < cnt);
  endfunction

  // buffer storage
  logic [BIT_NUMBER-1:0] res_q   [DEPTH];
  logic [BIT_NUMBER-1:0] res_d   [DEPTH];
  logic [REG_ADDR_W-1:0] dst_q   [DEPTH];
  logic [REG_ADDR_W-1:0] dst_d   [DEPTH];
  logic [1:0]            size_q  [DEPTH];
  logic [1:0]            size_d  [DEPTH];
  logic [1:0]            alo_q   [DEPTH];
  logic [1:0]            alo_d   [DEPTH];
  logic [DEPTH-1:0]      wben_q, wben_d;
  logic [DEPTH-1:0]      isld_q, isld_d;
  logic [DEPTH-1:0]      sgn_q,  sgn_d;
  logic [DEPTH-1:0]      dv_q,   dv_d;

  // pointers and occupancy
  ptr_t rd_ptr_q, rd_ptr_d;
  ptr_t wr_ptr_q, wr_ptr_d;
  cnt_t count_q,  count_d;

  // registered outputs
  logic [BIT_NUMBER-1:0] out_q,  out_d;
  logic                  wb_q,   wb_d;
  logic [REG_ADDR_W-1:0] dest_q, dest_d;
  logic                  err_q,  err_d;

  logic                  in_ready_s;
  logic                  accept_s;
  logic                  retire_s;
  logic                  match_found_s;
  ptr_t                  match_idx_s;
  logic [NREG-1:0]       busy_s;

  assign in_ready_s = (count_q != DEPTH_C);
  assign accept_s   = bus.in_valid && in_ready_s;
  assign retire_s   = (count_q != cnt_t'(0)) && (!isld_q[rd_ptr_q] || dv_q[rd_ptr_q]);

  // Finds the oldest occupied load still waiting for its memory word.
  always_comb begin
    logic found_v;
    ptr_t idx_v;
    found_v     = 1'b0;
    idx_v       = '0;
    match_idx_s = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx_v = rd_ptr_q + ptr_t'(k);
      if (!found_v && (cnt_t'(k) < count_q) && isld_q[idx_v] && !dv_q[idx_v]) begin
        found_v     = 1'b1;
        match_idx_s = idx_v;
      end else begin
        found_v     = found_v;
      end
    end
    match_found_s = found_v;
  end

  // Pending-write mask: one-hot destination of every live entry that writes.
  always_comb begin
    busy_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_live(ptr_t'(i), rd_ptr_q, count_q) && wben_q[i]) begin
        busy_s[dst_q[i]] = 1'b1;
      end else begin
        busy_s = busy_s;
      end
    end
  end

  // Next-state: response capture, head retirement and new-entry accept.
  always_comb begin
    res_d    = res_q;
    dst_d    = dst_q;
    size_d   = size_q;
    alo_d    = alo_q;
    wben_d   = wben_q;
    isld_d   = isld_q;
    sgn_d    = sgn_q;
    dv_d     = dv_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    out_d    = out_q;
    wb_d     = 1'b0;
    dest_d   = dest_q;
    err_d    = err_q;

    // the retiring head already holds its data, so it is never the match target
    if (bus.mem_rsp_valid) begin
      if (match_found_s) begin
        res_d[match_idx_s] = bus.mem_rsp_data;
        dv_d[match_idx_s]  = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end else begin
      err_d = err_q;
    end

    if (retire_s) begin
      rd_ptr_d = rd_ptr_q + ptr_t'(1);
      if (wben_q[rd_ptr_q]) begin
        wb_d   = 1'b1;
        dest_d = dst_q[rd_ptr_q];
        if (isld_q[rd_ptr_q]) begin
          out_d = extract_load(res_q[rd_ptr_q], size_q[rd_ptr_q],
                               sgn_q[rd_ptr_q], alo_q[rd_ptr_q]);
        end else begin
          out_d = res_q[rd_ptr_q];
        end
      end else begin
        wb_d = 1'b0;
      end
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    // the write slot is never live when accepting, so it cannot collide
    if (accept_s) begin
      res_d[wr_ptr_q]  = bus.ALU_result;
      dst_d[wr_ptr_q]  = bus.Dest_in;
      size_d[wr_ptr_q] = bus.ld_size;
      alo_d[wr_ptr_q]  = bus.ALU_result[1:0];
      wben_d[wr_ptr_q] = bus.WB_en_in;
      isld_d[wr_ptr_q] = bus.Mem_R_en;
      sgn_d[wr_ptr_q]  = bus.ld_signed;
      dv_d[wr_ptr_q]   = 1'b0;
      wr_ptr_d         = wr_ptr_q + ptr_t'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    count_d = count_q + cnt_t'(accept_s) - cnt_t'(retire_s);
  end

  // State and output registers; reset empties the buffer and zeroes outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        res_q[i]  <= '0;
        dst_q[i]  <= '0;
        size_q[i] <= 2'b00;
        alo_q[i]  <= 2'b00;
      end
      wben_q   <= '0;
      isld_q   <= '0;
      sgn_q    <= '0;
      dv_q     <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      out_q    <= '0;
      wb_q     <= 1'b0;
      dest_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      res_q    <= res_d;
      dst_q    <= dst_d;
      size_q   <= size_d;
      alo_q    <= alo_d;
      wben_q   <= wben_d;
      isld_q   <= isld_d;
      sgn_q    <= sgn_d;
      dv_q     <= dv_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      out_q    <= out_d;
      wb_q     <= wb_d;
      dest_q   <= dest_d;
      err_q    <= err_d;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out       = out_q;
  assign bus.WB_en     = wb_q;
  assign bus.Dest      = dest_q;
  assign bus.busy_mask = busy_s;
  assign bus.rsp_err   = err_q;
endmodule
